// File: rtl/fifo8x9_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo8x9_pkg
//  Description : Shared sizing constants and controller state encoding for
//                the 8x9 FIFO control slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo8x9_pkg;

  localparam int FIFO_DEPTH  = 8;
  localparam int FIFO_DATA_W = 9;
  localparam int FIFO_CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } fifo_ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/fifo8x9_occ_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : fifo8x9_occ_cnt
//  Description : Up/down occupancy counter with synchronous clear, full/empty
//                decode and optional registered almost-full/almost-empty.
//                Almost flags are built only when FIFO8X9_ALMOST_FLAGS_EN is
//                defined; otherwise they are tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo8x9_occ_cnt
  import fifo8x9_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int CNT_W = FIFO_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next occupancy: clear dominates; saturate at both ends as a safety net.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !dec && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end else if (dec && !inc && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign full  = (count_q == CNT_MAX);
  assign empty = (count_q == '0);

`ifdef FIFO8X9_ALMOST_FLAGS_EN
  localparam logic [CNT_W-1:0] AF_LEVEL = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] AE_LEVEL = CNT_W'(1);

  logic af_q;
  logic ae_q;

  // Almost flags registered from the next count so they line up with count.
  always_ff @(posedge clk) begin
    if (rst) begin
      af_q <= 1'b0;
      ae_q <= 1'b1;
    end else begin
      af_q <= (count_d >= AF_LEVEL);
      ae_q <= (count_d <= AE_LEVEL);
    end
  end

  assign almost_full  = af_q;
  assign almost_empty = ae_q;
`else
  assign almost_full  = 1'b0;
  assign almost_empty = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/fifo8x9_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fifo8x9_ctrl
//  Description : Control side of the 8x9 FIFO storage block. Converts push/pop
//                valid-ready handshakes into storage strobes, sequences the
//                pointer clears (INIT / FLUSH) and keeps a shadow occupancy.
//                Optional feature macro: FIFO8X9_ALMOST_FLAGS_EN enables the
//                almost_full / almost_empty flags (tied low otherwise).
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo8x9_ctrl
  import fifo8x9_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int CNT_W = FIFO_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic             pop_ready,
  output logic             pop_valid,
  output logic             rdata_valid,
  input  logic             flush,
  output logic             wren,
  output logic             WrInc,
  output logic             rden,
  output logic             RdInc,
  output logic             WrPtrClr,
  output logic             RdPtrClr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty
);

  localparam logic [1:0] S_INIT  = ST_INIT;
  localparam logic [1:0] S_RUN   = ST_RUN;
  localparam logic [1:0] S_FLUSH = ST_FLUSH;

  logic [1:0] state;
  logic [1:0] state_next;
  logic       in_run;
  logic       push_acc;
  logic       pop_acc;
  logic       cnt_clr;

  // State register; reset always lands in INIT so the pointers get cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_INIT;
    end else begin
      state <= state_next;
    end
  end

  // INIT and FLUSH are single-cycle clear states; only RUN reacts to flush.
  always_comb begin
    state_next = state;
    case (state)
      S_INIT:  state_next = S_RUN;
      S_RUN:   state_next = flush ? S_FLUSH : S_RUN;
      S_FLUSH: state_next = S_RUN;
      default: state_next = S_INIT;
    endcase
  end

  assign in_run     = (state == S_RUN);

  // A flush request blocks both handshakes in the same cycle.
  assign push_ready = in_run && !full  && !flush;
  assign pop_valid  = in_run && !empty && !flush;

  assign push_acc   = push_valid && push_ready;
  assign pop_acc    = pop_valid  && pop_ready;

  assign wren       = push_acc;
  assign WrInc      = push_acc;
  assign rden       = pop_acc;
  assign RdInc      = pop_acc;

  assign WrPtrClr   = (state == S_INIT) || (state == S_FLUSH);
  assign RdPtrClr   = (state == S_INIT) || (state == S_FLUSH);

  // Count is zeroed on the edge entering FLUSH and held at zero outside RUN.
  assign cnt_clr    = !in_run || flush;

  // Storage read data appears one cycle after the pop strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_valid <= 1'b0;
    end else begin
      rdata_valid <= pop_acc;
    end
  end

  fifo8x9_occ_cnt #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_occ_cnt (
    .clk          (clk),
    .rst          (rst),
    .clr          (cnt_clr),
    .inc          (push_acc),
    .dec          (pop_acc),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_fifo8x9_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo8x9_ctrl
//  Description : Directed self-checking bench for fifo8x9_ctrl. Expectations
//                for the almost flags follow FIFO8X9_ALMOST_FLAGS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo8x9_ctrl;

`ifdef FIFO8X9_ALMOST_FLAGS_EN
  localparam bit ALM = 1'b1;
`else
  localparam bit ALM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       push_valid;
  logic       push_ready;
  logic       pop_ready;
  logic       pop_valid;
  logic       rdata_valid;
  logic       flush;
  logic       wren, WrInc, rden, RdInc, WrPtrClr, RdPtrClr;
  logic [3:0] count;
  logic       full, empty, almost_full, almost_empty;

  int n_checks = 0;
  int n_fail   = 0;
  int nw, nr, nrv;

  always #5 clk = ~clk;

  fifo8x9_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .push_valid   (push_valid),
    .push_ready   (push_ready),
    .pop_ready    (pop_ready),
    .pop_valid    (pop_valid),
    .rdata_valid  (rdata_valid),
    .flush        (flush),
    .wren         (wren),
    .WrInc        (WrInc),
    .rden         (rden),
    .RdInc        (RdInc),
    .WrPtrClr     (WrPtrClr),
    .RdPtrClr     (RdPtrClr),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; push_valid = 1'b0; pop_ready = 1'b0; flush = 1'b0;
    tick();
    tick();

    // ---- 1. reset / INIT / RUN entry ----
    rst = 1'b0;
    #1;
    check("init_wrclr", WrPtrClr, 1);
    check("init_rdclr", RdPtrClr, 1);
    check("init_count", count, 0);
    check("init_empty", empty, 1);
    check("init_full", full, 0);
    check("init_push_ready", push_ready, 0);
    check("init_pop_valid", pop_valid, 0);
    check("init_rdata_valid", rdata_valid, 0);
    check("init_almost_full", almost_full, 0);
    check("init_almost_empty", almost_empty, ALM);
    tick();
    #1;
    check("run_wrclr", WrPtrClr, 0);
    check("run_rdclr", RdPtrClr, 0);
    check("run_push_ready", push_ready, 1);
    check("run_pop_valid", pop_valid, 0);

    // ---- 2. 8 pushes then a refused 9th ----
    nw = 0;
    push_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      #1;
      check("fill_count", count, (i > 8) ? 8 : i);
      check("fill_wren", wren, (i < 8) ? 1 : 0);
      check("fill_wrinc", WrInc, (i < 8) ? 1 : 0);
      check("fill_rden", rden, 0);
      check("fill_almost_full", almost_full, ALM && (i >= 7));
      check("fill_almost_empty", almost_empty, ALM && (i <= 1));
      if (wren) nw++;
      tick();
    end
    push_valid = 1'b0;
    #1;
    check("fill_pulses", nw, 8);
    check("full_count", count, 8);
    check("full_flag", full, 1);
    check("full_push_ready", push_ready, 0);
    check("full_pop_valid", pop_valid, 1);

    // ---- 3. drain 8 with rdata_valid one cycle later ----
    nr = 0; nrv = 0;
    pop_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      #1;
      check("drain_count", count, 8 - i);
      check("drain_rden", rden, (i < 8) ? 1 : 0);
      check("drain_rdinc", RdInc, (i < 8) ? 1 : 0);
      check("drain_rdata_valid", rdata_valid, (i > 0) ? 1 : 0);
      if (rden) nr++;
      if (rdata_valid) nrv++;
      tick();
    end
    pop_ready = 1'b0;
    #1;
    check("drain_pulses", nr, 8);
    check("drain_rv_pulses", nrv, 8);
    check("drain_empty", empty, 1);
    check("drain_pop_valid", pop_valid, 0);
    check("drain_rdata_valid_off", rdata_valid, 0);

    // ---- 4. count=4, push+pop for 10 cycles ----
    push_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    push_valid = 1'b0;
    #1;
    check("mid_count", count, 4);
    nw = 0; nr = 0;
    push_valid = 1'b1; pop_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("both_count", count, 4);
      if (wren) nw++;
      if (rden) nr++;
      tick();
    end
    push_valid = 1'b0; pop_ready = 1'b0;
    #1;
    check("both_wr_pulses", nw, 10);
    check("both_rd_pulses", nr, 10);
    check("both_count_after", count, 4);

    // ---- 5. flush at count=5 with pending handshakes ----
    push_valid = 1'b1;
    tick(); tick();                 // count 6
    push_valid = 1'b0; pop_ready = 1'b1;
    tick();                         // pop -> count 5, rdata_valid next
    flush = 1'b1; push_valid = 1'b1; pop_ready = 1'b1;
    #1;
    check("flush_count", count, 5);
    check("flush_wren", wren, 0);
    check("flush_rden", rden, 0);
    check("flush_push_ready", push_ready, 0);
    check("flush_prior_rdata_valid", rdata_valid, 1);
    tick();
    flush = 1'b0; pop_ready = 1'b0;
    #1;
    check("flushst_wrclr", WrPtrClr, 1);
    check("flushst_rdclr", RdPtrClr, 1);
    check("flushst_count", count, 0);
    check("flushst_wren", wren, 0);
    check("flushst_rdata_valid", rdata_valid, 0);
    tick();
    #1;
    check("resume_clr", WrPtrClr, 0);
    check("resume_push_ready", push_ready, 1);
    check("resume_wren", wren, 1);
    tick();
    push_valid = 1'b0;
    #1;
    check("resume_count", count, 1);
    check("one_almost_empty", almost_empty, ALM);
    check("one_almost_full", almost_full, 0);

    // ---- 6. reset mid-operation drops in-flight rdata_valid ----
    pop_ready = 1'b1; rst = 1'b1;
    #1;
    check("rstpop_rden", rden, 1);
    tick();
    pop_ready = 1'b0;
    #1;
    check("rst_rdata_valid", rdata_valid, 0);
    check("rst_count", count, 0);
    check("rst_clear", WrPtrClr, 1);
    rst = 1'b0;
    tick();
    #1;
    check("rst_resume_push_ready", push_ready, 1);
    check("rst_resume_clear", RdPtrClr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
